inst_cache: RTL and testbench



---
 rtl/cpu_defs.sv | 20 ++
 rtl/icache_array.sv | 52 +++++
 rtl/inst_cache.sv | 162 ++++++++++++++++
 tb/tb_inst_cache.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs
// Description : Shared widths and instruction-cache FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  typedef logic [1:0] ic_state_t;

  localparam ic_state_t IC_IDLE      = 2'd0;
  localparam ic_state_t IC_MISS_REQ  = 2'd1;
  localparam ic_state_t IC_MISS_WAIT = 2'd2;
  localparam ic_state_t IC_DISCARD   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Direct-mapped valid/tag/data storage; async read, sync write,
//               sync invalidate-all on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24,
  parameter int DATA_WIDTH = cpu_defs::INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);

  localparam int c_LINES = 2 ** INDEX_BITS;

  logic [c_LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0]   r_tag  [c_LINES];
  logic [DATA_WIDTH-1:0] r_data [c_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache
// Description : Direct-mapped one-word-per-line instruction cache with a
//               single-word refill FSM toward the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = cpu_defs::ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  _clear,
  input  logic                  _req_valid,
  input  logic [ADDR_WIDTH-1:0] _req_pc,
  output logic                  _inst_ready_out,
  output logic [31:0]           _inst_out,
  output logic                  _busy,
  input  logic                  _mem_busy,
  output logic                  _mem_req,
  output logic [ADDR_WIDTH-1:0] _mem_addr,
  input  logic                  _mem_ready_in,
  input  logic [31:0]           _mem_data_in
);

  import cpu_defs::*;

  localparam int c_TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  ic_state_t r_state;
  ic_state_t w_next_state;

  logic [ADDR_WIDTH-3:0] r_miss_word;
  logic                  r_inst_ready;
  logic [INST_WIDTH-1:0] r_inst_out;

  logic [INDEX_BITS-1:0] w_req_index;
  logic [c_TAG_BITS-1:0] w_req_tag;
  logic [INDEX_BITS-1:0] w_miss_index;
  logic [c_TAG_BITS-1:0] w_miss_tag;
  logic                  w_rd_valid;
  logic [c_TAG_BITS-1:0] w_rd_tag;
  logic [INST_WIDTH-1:0] w_rd_data;
  logic                  w_hit;
  logic                  w_latch_miss;
  logic                  w_mem_req;
  logic                  w_wr_en;
  logic                  w_pulse;
  logic [INST_WIDTH-1:0] w_pulse_data;
  logic                  w_unused;

  assign w_req_index  = _req_pc[INDEX_BITS+1:2];
  assign w_req_tag    = _req_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_miss_index = r_miss_word[INDEX_BITS-1:0];
  assign w_miss_tag   = r_miss_word[ADDR_WIDTH-3:INDEX_BITS];
  assign w_unused     = &{1'b0, _req_pc[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (c_TAG_BITS),
    .DATA_WIDTH (INST_WIDTH)
  ) u_array (
    .clk        (clk_in),
    .rst        (rst_in),
    .i_rd_index (w_req_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_index (w_miss_index),
    .i_wr_tag   (w_miss_tag),
    .i_wr_data  (_mem_data_in)
  );

  assign w_hit = w_rd_valid && (w_rd_tag == w_req_tag);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IC_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IC_IDLE: begin
        if (!_clear && _req_valid && !w_hit) w_next_state = IC_MISS_REQ;
      end
      IC_MISS_REQ: begin
        if (_clear)          w_next_state = IC_IDLE;
        else if (!_mem_busy) w_next_state = IC_MISS_WAIT;
      end
      IC_MISS_WAIT: begin
        if (_mem_ready_in) w_next_state = IC_IDLE;
        else if (_clear)   w_next_state = IC_DISCARD;
      end
      IC_DISCARD: begin
        if (_mem_ready_in) w_next_state = IC_IDLE;
      end
      default: w_next_state = IC_IDLE;
    endcase
  end

  // Output/control decode; everything is gated by rdy_in so a stall freezes it.
  always_comb begin
    w_latch_miss = 1'b0;
    w_mem_req    = 1'b0;
    w_wr_en      = 1'b0;
    w_pulse      = 1'b0;
    w_pulse_data = w_rd_data;
    if (rdy_in) begin
      case (r_state)
        IC_IDLE: begin
          if (!_clear && _req_valid) begin
            w_pulse      = w_hit;
            w_latch_miss = !w_hit;
          end
        end
        IC_MISS_REQ: begin
          w_mem_req = !_clear && !_mem_busy;
        end
        IC_MISS_WAIT: begin
          if (_mem_ready_in) begin
            w_wr_en      = 1'b1;
            w_pulse      = !_clear;
            w_pulse_data = _mem_data_in;
          end
        end
        IC_DISCARD: begin
          w_wr_en = _mem_ready_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_miss_word  <= '0;
      r_inst_ready <= 1'b0;
      r_inst_out   <= '0;
    end else begin
      r_inst_ready <= w_pulse;
      if (w_pulse)      r_inst_out  <= w_pulse_data;
      if (w_latch_miss) r_miss_word <= _req_pc[ADDR_WIDTH-1:2];
    end
  end

  assign _inst_ready_out = r_inst_ready;
  assign _inst_out       = r_inst_out;
  assign _busy           = (r_state != IC_IDLE);
  assign _mem_req        = w_mem_req;
  assign _mem_addr       = {r_miss_word, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_cache
// Description : Directed self-checking bench for inst_cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        _clear;
  logic        _req_valid;
  logic [31:0] _req_pc;
  logic        _inst_ready_out;
  logic [31:0] _inst_out;
  logic        _busy;
  logic        _mem_busy;
  logic        _mem_req;
  logic [31:0] _mem_addr;
  logic        _mem_ready_in;
  logic [31:0] _mem_data_in;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  inst_cache dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    ._clear          (_clear),
    ._req_valid      (_req_valid),
    ._req_pc         (_req_pc),
    ._inst_ready_out (_inst_ready_out),
    ._inst_out       (_inst_out),
    ._busy           (_busy),
    ._mem_busy       (_mem_busy),
    ._mem_req        (_mem_req),
    ._mem_addr       (_mem_addr),
    ._mem_ready_in   (_mem_ready_in),
    ._mem_data_in    (_mem_data_in)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issues one missing fetch and plays the memory side; returns what it saw.
  task automatic miss_refill(input logic [31:0] pc, input logic [31:0] data,
                             input int busy_cycles, output int req_cnt,
                             output int req_cyc, output logic [31:0] req_addr,
                             output int busy_hi, output logic got_ready,
                             output logic [31:0] got_data);
    int since;
    since = -1; req_cnt = 0; req_cyc = -1; req_addr = '0;
    busy_hi = 0; got_ready = 1'b0; got_data = '0;
    _mem_busy = (busy_cycles > 0);
    _req_valid = 1'b1; _req_pc = pc;
    tick();
    _req_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_ready; cyc++) begin
      _mem_busy     = (cyc < busy_cycles);
      _mem_ready_in = (since == 2);
      _mem_data_in  = (since == 2) ? data : 32'h0;
      #1;
      if (_busy) busy_hi++;
      if (_mem_req) begin
        req_cnt++; req_cyc = cyc; req_addr = _mem_addr; since = 0;
      end else if (since >= 0) begin
        since++;
      end
      tick();
      _mem_ready_in = 1'b0;
      if (_inst_ready_out) begin
        got_ready = 1'b1; got_data = _inst_out;
      end
    end
    _mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _req_valid = 1'b0;
    _req_pc = '0; _mem_busy = 1'b0; _mem_ready_in = 1'b0; _mem_data_in = '0;
    tick(); tick();
    rst_in = 1'b0;
    #1;
    n_cmp++; if (_inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", _inst_ready_out); end
    n_cmp++; if (_inst_out !== 32'h0) begin n_bad++; $display("FAIL reset_inst got=%h exp=0", _inst_out); end
    n_cmp++; if (_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", _busy); end
    n_cmp++; if (_mem_req !== 1'b0 || _mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem got=%b/%h exp=0/0", _mem_req, _mem_addr); end
  endtask

  task automatic test_cold_miss_hit();
    int rc, rcyc, bh; logic [31:0] ra, gd; logic gr;
    tick();
    miss_refill(32'h0000_1004, 32'h00A0_0093, 0, rc, rcyc, ra, bh, gr, gd);
    n_cmp++; if (rc !== 1 || ra !== 32'h0000_1004) begin n_bad++; $display("FAIL cold_memreq got=%0d/%h exp=1/00001004", rc, ra); end
    n_cmp++; if (gr !== 1'b1 || gd !== 32'h00A0_0093) begin n_bad++; $display("FAIL cold_data got=%b/%h exp=1/00a00093", gr, gd); end
    n_cmp++; if (bh !== 4) begin n_bad++; $display("FAIL cold_busy_cycles got=%0d exp=4", bh); end
    n_cmp++; if (_busy !== 1'b0) begin n_bad++; $display("FAIL cold_idle_after got=%b exp=0", _busy); end
    tick();
    n_cmp++; if (_inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL cold_single_pulse got=%b exp=0", _inst_ready_out); end
    // Hit, twice back to back, low PC bits ignored on the second.
    _req_valid = 1'b1; _req_pc = 32'h0000_1004;
    #1;
    n_cmp++; if (_mem_req !== 1'b0 || _busy !== 1'b0) begin n_bad++; $display("FAIL hit_no_memreq got=%b/%b exp=0/0", _mem_req, _busy); end
    tick();
    n_cmp++; if (_inst_ready_out !== 1'b1 || _inst_out !== 32'h00A0_0093) begin n_bad++; $display("FAIL hit_data got=%b/%h exp=1/00a00093", _inst_ready_out, _inst_out); end
    _req_pc = 32'h0000_1007;
    tick();
    n_cmp++; if (_inst_ready_out !== 1'b1 || _busy !== 1'b0) begin n_bad++; $display("FAIL hit_b2b got=%b/%b exp=1/0", _inst_ready_out, _busy); end
    _clear = 1'b1;
    tick();
    _clear = 1'b0; _req_valid = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL clear_wins_idle got=%b exp=0", _inst_ready_out); end
  endtask

  task automatic test_conflict();
    int rc, rcyc, bh; logic [31:0] ra, gd; logic gr;
    miss_refill(32'h0000_1104, 32'h1111_1111, 0, rc, rcyc, ra, bh, gr, gd);
    n_cmp++; if (rc !== 1 || ra !== 32'h0000_1104 || gd !== 32'h1111_1111) begin n_bad++; $display("FAIL evict_fill got=%0d/%h/%h exp=1/00001104/11111111", rc, ra, gd); end
    miss_refill(32'h0000_1004, 32'h00A0_0093, 0, rc, rcyc, ra, bh, gr, gd);
    n_cmp++; if (rc !== 1 || gr !== 1'b1 || gd !== 32'h00A0_0093) begin n_bad++; $display("FAIL evict_remiss got=%0d/%b/%h exp=1/1/00a00093", rc, gr, gd); end
  endtask

  task automatic test_mem_busy();
    int rc, rcyc, bh; logic [31:0] ra, gd; logic gr;
    miss_refill(32'h0000_2008, 32'h1234_5678, 5, rc, rcyc, ra, bh, gr, gd);
    n_cmp++; if (rc !== 1 || rcyc !== 5) begin n_bad++; $display("FAIL busy_memreq got=%0d@%0d exp=1@5", rc, rcyc); end
    n_cmp++; if (bh !== 9) begin n_bad++; $display("FAIL busy_held got=%0d exp=9", bh); end
    n_cmp++; if (gd !== 32'h1234_5678) begin n_bad++; $display("FAIL busy_data got=%h exp=12345678", gd); end
  endtask

  task automatic test_clear_wait();
    _req_valid = 1'b1; _req_pc = 32'h0000_3000;
    tick();
    _req_valid = 1'b0;
    #1;
    n_cmp++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h0000_3000) begin n_bad++; $display("FAIL cw_memreq got=%b/%h exp=1/00003000", _mem_req, _mem_addr); end
    tick();
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b0 || _busy !== 1'b1) begin n_bad++; $display("FAIL cw_discard got=%b/%b exp=0/1", _inst_ready_out, _busy); end
    tick();
    _mem_ready_in = 1'b1; _mem_data_in = 32'hDEAD_BEEF;
    tick();
    _mem_ready_in = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b0 || _busy !== 1'b0) begin n_bad++; $display("FAIL cw_no_pulse got=%b/%b exp=0/0", _inst_ready_out, _busy); end
    _req_valid = 1'b1; _req_pc = 32'h0000_3000;
    #1;
    n_cmp++; if (_mem_req !== 1'b0) begin n_bad++; $display("FAIL cw_rehit_memreq got=%b exp=0", _mem_req); end
    tick();
    _req_valid = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b1 || _inst_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL cw_rehit got=%b/%h exp=1/deadbeef", _inst_ready_out, _inst_out); end
  endtask

  task automatic test_clear_req();
    int seen;
    seen = 0;
    _mem_busy = 1'b1; _req_valid = 1'b1; _req_pc = 32'h0000_4000;
    tick();
    _req_valid = 1'b0; _clear = 1'b1;
    #1;
    if (_mem_req) seen++;
    tick();
    _clear = 1'b0;
    n_cmp++; if (_busy !== 1'b0) begin n_bad++; $display("FAIL cr_idle got=%b exp=0", _busy); end
    _mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; if (_mem_req) seen++;
      tick();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL cr_no_memreq got=%0d exp=0", seen); end
  endtask

  task automatic test_stall_and_reset();
    int pulses;
    pulses = 0;
    _req_valid = 1'b1; _req_pc = 32'h0000_5004;
    tick();
    _req_valid = 1'b0;
    tick();
    rdy_in = 1'b0; _mem_ready_in = 1'b1; _mem_data_in = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (_inst_ready_out) pulses++;
      if (!_busy) pulses += 100;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL stall_frozen got=%0d exp=0", pulses); end
    rdy_in = 1'b1;
    tick();
    _mem_ready_in = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b1 || _inst_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL stall_release got=%b/%h exp=1/cafef00d", _inst_ready_out, _inst_out); end
    tick();
    n_cmp++; if (_inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL stall_one_pulse got=%b exp=0", _inst_ready_out); end
    _req_valid = 1'b1;
    tick();
    _req_valid = 1'b0;
    n_cmp++; if (_inst_ready_out !== 1'b1 || _busy !== 1'b0) begin n_bad++; $display("FAIL stall_hit got=%b/%b exp=1/0", _inst_ready_out, _busy); end
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    _req_valid = 1'b1; _req_pc = 32'h0000_5004;
    tick();
    _req_valid = 1'b0;
    #1;
    n_cmp++; if (_busy !== 1'b1 || _mem_req !== 1'b1 || _inst_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_invalidates got=%b/%b/%b exp=1/1/0", _busy, _mem_req, _inst_ready_out); end
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_conflict();
    test_mem_busy();
    test_clear_wait();
    test_clear_req();
    test_stall_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
